// File: rtl/rx_frame_dma_feeder_pkg.sv
// Shared types for the receive frame DMA feeder: read FSM states, frame-info entries and
// last-beat byte-enable helpers.
package rx_frame_dma_feeder_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_STAT} state_e;

  // Info entries carry a fixed-width length; the top clamps it to its own LENGTH_BITS.
  localparam int unsigned MaxLenBits = 32;

  typedef struct packed {
    logic [MaxLenBits-1:0] bytes;
    logic                  err;
  } info_t;

  function automatic logic [3:0] tail_keep(input logic [1:0] rem);
    case (rem)
      2'd0:    tail_keep = 4'hF;
      2'd1:    tail_keep = 4'h1;
      2'd2:    tail_keep = 4'h3;
      default: tail_keep = 4'h7;
    endcase
  endfunction

  function automatic logic [2:0] keep_count(input logic [3:0] keep);
    keep_count = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
  endfunction

endpackage

// File: rtl/rx_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port; read data holds
// its value while rd_en is low.
module rx_sdp_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          aclk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_frame_dma_feeder.sv
// Store-and-forward stage from the RX MAC stream to the write DMA: buffers whole frames,
// issues one command per frame, streams the words, reports status. RX_ERR_DROP_EN drops errored frames.
module rx_frame_dma_feeder
  import rx_frame_dma_feeder_pkg::*;
#(
  parameter int unsigned DATA_AW      = 10,
  parameter int unsigned INFO_AW      = 4,
  parameter int unsigned ADDRESS_BITS = 32,
  parameter int unsigned LENGTH_BITS  = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [31:0]             s_tdata,
  input  logic [3:0]              s_tkeep,
  input  logic                    s_tuser,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [ADDRESS_BITS-1:0] buf_addr,
  input  logic                    buf_valid,
  output logic                    buf_ready,
  output logic [ADDRESS_BITS-1:0] cmd_address,
  output logic [LENGTH_BITS-1:0]  cmd_bytes,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [31:0]             m_tdata,
  output logic [3:0]              m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [ADDRESS_BITS-1:0] stat_address,
  output logic [LENGTH_BITS-1:0]  stat_bytes,
  output logic                    stat_err,
  output logic                    stat_valid,
  input  logic                    stat_ready
);

`ifdef RX_ERR_DROP_EN
  localparam bit ErrDrop = 1'b1;
`else
  localparam bit ErrDrop = 1'b0;
`endif

  localparam int unsigned PW  = DATA_AW + 1;
  localparam int unsigned IW  = INFO_AW + 1;
  localparam int unsigned LW1 = LENGTH_BITS + 1;

  // Write side
  logic                   ready_q;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LENGTH_BITS-1:0] byte_cnt_q, byte_cnt_d;
  logic                   trunc_q, trunc_d;
  logic [IW-1:0]          info_wr_q, info_rd_q;
  info_t                  info_mem [0:(1<<INFO_AW)-1];
  logic                   info_full, info_empty, data_full;
  logic                   beat, store, dropped, push, pop;
  logic [LW1-1:0]         sum;
  logic [LENGTH_BITS-1:0] frame_bytes;
  logic                   frame_err;

  assign info_full  = (info_wr_q[INFO_AW] != info_rd_q[INFO_AW]) &&
                      (info_wr_q[INFO_AW-1:0] == info_rd_q[INFO_AW-1:0]);
  assign info_empty = (info_wr_q == info_rd_q);
  assign data_full  = (wr_ptr_q[DATA_AW] != rd_ptr_q[DATA_AW]) &&
                      (wr_ptr_q[DATA_AW-1:0] == rd_ptr_q[DATA_AW-1:0]);

  // Held low through reset so nothing is accepted before the pointers are sane.
  assign s_tready = ready_q && !info_full;
  assign beat     = s_tvalid && s_tready;

  always_comb begin
    store        = beat && (s_tkeep != 4'h0) && !trunc_q && !data_full;
    dropped      = beat && (s_tkeep != 4'h0) && !trunc_q && data_full;
    sum          = {1'b0, byte_cnt_q} + LW1'(store ? keep_count(s_tkeep) : 3'd0);
    frame_bytes  = sum[LENGTH_BITS] ? '1 : sum[LENGTH_BITS-1:0];
    frame_err    = s_tuser || trunc_q || dropped;
    wr_ptr_d     = wr_ptr_q + PW'(store);
    commit_ptr_d = commit_ptr_q;
    byte_cnt_d   = byte_cnt_q;
    trunc_d      = trunc_q;
    push         = 1'b0;
    if (beat) begin
      byte_cnt_d = frame_bytes;
      trunc_d    = trunc_q || dropped;
      if (s_tlast) begin
        byte_cnt_d = '0;
        trunc_d    = 1'b0;
        if ((frame_bytes == '0) || (ErrDrop && frame_err)) begin
          wr_ptr_d = commit_ptr_q;
        end else begin
          commit_ptr_d = wr_ptr_d;
          push         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      info_mem[info_wr_q[INFO_AW-1:0]] <= '{bytes: MaxLenBits'(frame_bytes), err: frame_err};
    end
  end

  // Read side
  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [LENGTH_BITS-1:0]  bytes_q, bytes_d, fetch_left_q, fetch_left_d, send_left_q, send_left_d;
  logic [LENGTH_BITS-1:0]  head_bytes, words;
  logic [MaxLenBits-1:0]   head_raw;
  logic                    err_q, err_d, m_valid_q, m_valid_d, rd_en;
  info_t                   info_head;

  assign info_head = info_mem[info_rd_q[INFO_AW-1:0]];
  assign head_raw  = info_head.bytes;

  always_comb begin
    head_bytes = head_raw[LENGTH_BITS-1:0];
    if ((head_raw >> LENGTH_BITS) != '0) head_bytes = '1;
    words = LENGTH_BITS'(({1'b0, head_bytes} + LW1'(3)) >> 2);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bytes_d      = bytes_q;
    err_d        = err_q;
    fetch_left_d = fetch_left_q;
    send_left_d  = send_left_q;
    m_valid_d    = m_valid_q;
    rd_ptr_d     = rd_ptr_q;
    rd_en        = 1'b0;
    pop          = 1'b0;
    cmd_valid    = 1'b0;
    buf_ready    = 1'b0;
    stat_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!info_empty && buf_valid) state_d = S_CMD;
      end
      S_CMD: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          buf_ready    = 1'b1;
          addr_d       = buf_addr;
          bytes_d      = head_bytes;
          err_d        = info_head.err;
          fetch_left_d = words;
          send_left_d  = words;
          state_d      = S_DATA;
        end
      end
      S_DATA: begin
        // The RAM output register is the m_tdata holding stage: only re-read when it drains.
        rd_en = (fetch_left_q != '0) && (rd_ptr_q != commit_ptr_q) && (!m_valid_q || m_tready);
        if (rd_en) begin
          rd_ptr_d     = rd_ptr_q + PW'(1);
          fetch_left_d = fetch_left_q - LENGTH_BITS'(1);
          m_valid_d    = 1'b1;
        end else if (m_valid_q && m_tready) begin
          m_valid_d = 1'b0;
        end
        if (m_valid_q && m_tready) begin
          send_left_d = send_left_q - LENGTH_BITS'(1);
          if (send_left_q == LENGTH_BITS'(1)) begin
            pop     = 1'b1;
            state_d = S_STAT;
          end
        end
      end
      S_STAT: begin
        stat_valid = 1'b1;
        if (stat_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q      <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      trunc_q      <= 1'b0;
      info_wr_q    <= '0;
      info_rd_q    <= '0;
      state_q      <= S_IDLE;
      addr_q       <= '0;
      bytes_q      <= '0;
      err_q        <= 1'b0;
      fetch_left_q <= '0;
      send_left_q  <= '0;
      m_valid_q    <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      trunc_q      <= trunc_d;
      info_wr_q    <= info_wr_q + IW'(push);
      info_rd_q    <= info_rd_q + IW'(pop);
      state_q      <= state_d;
      addr_q       <= addr_d;
      bytes_q      <= bytes_d;
      err_q        <= err_d;
      fetch_left_q <= fetch_left_d;
      send_left_q  <= send_left_d;
      m_valid_q    <= m_valid_d;
    end
  end

  rx_sdp_ram #(
    .AW(DATA_AW),
    .DW(32)
  ) u_data_ram (
    .aclk   (aclk),
    .wr_en  (store),
    .wr_addr(wr_ptr_q[DATA_AW-1:0]),
    .wr_data(s_tdata),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr_q[DATA_AW-1:0]),
    .rd_data(m_tdata)
  );

  assign cmd_address  = buf_addr;
  assign cmd_bytes    = head_bytes;
  assign m_tvalid     = m_valid_q;
  assign m_tlast      = m_valid_q && (send_left_q == LENGTH_BITS'(1));
  assign m_tkeep      = m_tlast ? tail_keep(bytes_q[1:0]) : 4'hF;
  assign stat_address = addr_q;
  assign stat_bytes   = bytes_q;
  assign stat_err     = err_q;

endmodule

// File: tb/tb_rx_frame_dma_feeder.sv
// Randomized bench for rx_frame_dma_feeder with a frame-level reference model
// (expected frames and words queued when each input frame completes).
module tb_rx_frame_dma_feeder;

  localparam int unsigned DataAw = 10;
  localparam int unsigned Depth  = 1 << DataAw;
  localparam int          NoCap  = 1 << 30;

`ifdef RX_ERR_DROP_EN
  localparam bit Drop = 1'b1;
`else
  localparam bit Drop = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tuser = 1'b0, s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [31:0] buf_addr = 32'h1000_0002;
  logic        buf_valid = 1'b0, buf_ready;
  logic [31:0] cmd_address;
  logic [15:0] cmd_bytes;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready = 1'b0;
  logic [31:0] stat_address;
  logic [15:0] stat_bytes;
  logic        stat_err, stat_valid, stat_ready = 1'b0;

  rx_frame_dma_feeder #(
    .DATA_AW(DataAw),
    .INFO_AW(4),
    .ADDRESS_BITS(32),
    .LENGTH_BITS(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .buf_addr(buf_addr), .buf_valid(buf_valid), .buf_ready(buf_ready),
    .cmd_address(cmd_address), .cmd_bytes(cmd_bytes), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .stat_address(stat_address), .stat_bytes(stat_bytes), .stat_err(stat_err),
    .stat_valid(stat_valid), .stat_ready(stat_ready)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_keep(input int nbytes);
    int rem;
    rem = nbytes % 4;
    return (rem == 0) ? 4'hF : 4'((1 << rem) - 1);
  endfunction

  function automatic logic [31:0] keep_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // Reference model state
  typedef struct {
    int bytes;
    bit err;
  } frame_t;
  frame_t      exp_frames[$];
  logic [31:0] exp_words[$];

  bit          bp_en = 1'b0, buf_en = 1'b0, chk_lat = 1'b0, take_buf = 1'b0, cmd_prev = 1'b0;
  int          cyc = 0, tlast_cyc = 0, first_m_cyc = 0, beats_left = 0, beats_total = 0;
  int          bufs_taken = 0;
  logic [31:0] cur_addr = '0;

  // Handshake driver: ready/valid inputs change just after the active edge.
  always @(posedge aclk) begin
    #1;
    m_tready   = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    stat_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    cmd_ready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    if (take_buf) begin
      buf_addr = $urandom;
      take_buf = 1'b0;
    end
    buf_valid = buf_en;
  end

  // Monitor: values at the falling edge are what the next rising edge will sample.
  always @(negedge aclk) begin
    logic [31:0] w;
    logic [3:0]  k;
    bit          last;
    cyc++;
    if (!aresetn) begin
      cmd_prev = 1'b0;
    end else begin
      if (s_tvalid && s_tready && s_tlast) tlast_cyc = cyc;
      if (chk_lat && cmd_valid && !cmd_prev) check("cmd_latency", 64'(cyc - tlast_cyc), 64'd2);
      cmd_prev = cmd_valid;
      if (buf_valid && buf_ready) begin
        bufs_taken++;
        take_buf = 1'b1;
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_frames.size() == 0) begin
          check("cmd_unexpected", 64'd1, 64'd0);
        end else begin
          check("cmd_bytes", 64'(cmd_bytes), 64'(exp_frames[0].bytes));
          check("cmd_address", 64'(cmd_address), 64'(buf_addr));
          cur_addr    = buf_addr;
          beats_total = (exp_frames[0].bytes + 3) / 4;
          beats_left  = beats_total;
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_words.size() == 0 || exp_frames.size() == 0 || beats_left == 0) begin
          check("m_unexpected", 64'd1, 64'd0);
        end else begin
          w    = exp_words.pop_front();
          last = (beats_left == 1);
          k    = last ? exp_keep(exp_frames[0].bytes) : 4'hF;
          if (beats_left == beats_total) first_m_cyc = cyc;
          check("m_tkeep", 64'(m_tkeep), 64'(k));
          check("m_tlast", 64'(m_tlast), 64'(last));
          check("m_tdata", 64'(m_tdata & keep_mask(k)), 64'(w & keep_mask(k)));
          if (chk_lat && last)
            check("m_throughput", 64'(cyc - first_m_cyc), 64'(beats_total - 1));
          beats_left--;
        end
      end
      if (stat_valid && stat_ready) begin
        if (exp_frames.size() == 0) begin
          check("stat_unexpected", 64'd1, 64'd0);
        end else begin
          check("stat_bytes", 64'(stat_bytes), 64'(exp_frames[0].bytes));
          check("stat_err", 64'(stat_err), 64'(exp_frames[0].err));
          check("stat_address", 64'(stat_address), 64'(cur_addr));
          check("stat_beats_left", 64'(beats_left), 64'd0);
          void'(exp_frames.pop_front());
        end
      end
    end
  end

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge aclk);
    while (!s_tready && n < 5000) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 5000) check("s_tready_timeout", 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1;
  endtask

  // cap: free data-FIFO words at frame start, valid only when nothing drains meanwhile.
  task automatic send_frame(input int len, input bit user, input int cap);
    int          nb, kb, st_words, st_bytes;
    bit          trunc, err;
    logic [31:0] d;
    logic [31:0] words[$];
    nb       = (len == 0) ? 1 : (len + 3) / 4;
    st_words = 0;
    st_bytes = 0;
    trunc    = 1'b0;
    for (int i = 0; i < nb; i++) begin
      d  = $urandom;
      kb = (i == nb - 1) ? len - 4 * (nb - 1) : 4;
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge aclk);
        #1;
      end
      s_tdata  = d;
      s_tkeep  = (kb == 4) ? 4'hF : 4'((1 << kb) - 1);
      s_tlast  = (i == nb - 1);
      s_tuser  = (i == nb - 1) ? user : 1'($urandom_range(0, 1));
      s_tvalid = 1'b1;
      wait_accept();
      if (kb > 0) begin
        if (!trunc && st_words < cap) begin
          words.push_back(d);
          st_words++;
          st_bytes += kb;
        end else begin
          trunc = 1'b1;
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    err      = user | trunc;
    if (st_bytes > 0 && !(Drop && err)) begin
      exp_frames.push_back('{bytes: st_bytes, err: err});
      foreach (words[j]) exp_words.push_back(words[j]);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_frames.size() != 0 && n < budget) begin
      @(posedge aclk);
      n++;
    end
    check("drain_pending_frames", 64'(exp_frames.size()), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    int b0, n;
    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_stat_valid", 64'(stat_valid), 64'd0);
    check("rst_buf_ready", 64'(buf_ready), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("s_tready_after_reset", 64'(s_tready), 64'd1);

    // Directed frames with no backpressure
    buf_en  = 1'b1;
    chk_lat = 1'b1;
    b0      = bufs_taken;
    send_frame(64, 1'b0, NoCap);
    drain(2000);
    chk_lat = 1'b0;
    check("first_addr_consumed", 64'(cur_addr), 64'h1000_0002);
    send_frame(61, 1'b0, NoCap);
    send_frame(40, 1'b1, NoCap);
    send_frame(20, 1'b0, NoCap);
    drain(4000);
    check("directed_bufs", 64'(bufs_taken - b0), Drop ? 64'd3 : 64'd4);

    // Random frames under backpressure; <=60 words each so 17 in flight never overflow
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++)
      send_frame($urandom_range(0, 240), ($urandom_range(0, 7) == 0), NoCap);
    drain(30000);

    // Oversize frame into an empty data FIFO
    send_frame(4 * Depth + 300, 1'b0, Depth);
    drain(20000);
    send_frame(60, 1'b0, NoCap);
    drain(2000);

    // Fill the info FIFO with no buffers offered
    buf_en = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    b0 = bufs_taken;
    for (int i = 0; i < 16; i++) send_frame(60, 1'b0, NoCap);
    check("s_tready_info_full", 64'(s_tready), 64'd0);
    check("no_buf_while_disabled", 64'(bufs_taken - b0), 64'd0);
    buf_en = 1'b1;
    send_frame(60, 1'b0, NoCap);
    drain(20000);
    check("info_full_bufs", 64'(bufs_taken - b0), 64'd17);

    // Reset in the middle of traffic
    send_frame(200, 1'b0, NoCap);
    n = 0;
    while (!m_tvalid && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    #1;
    for (int i = 0; i < 5; i++) begin
      s_tdata  = $urandom;
      s_tkeep  = 4'hF;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      wait_accept();
    end
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    #1;
    exp_frames.delete();
    exp_words.delete();
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    check("midrst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_m_tlast", 64'(m_tlast), 64'd0);
    check("midrst_stat_valid", 64'(stat_valid), 64'd0);
    check("midrst_buf_ready", 64'(buf_ready), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("s_tready_after_midrst", 64'(s_tready), 64'd1);
    send_frame(90, 1'b0, NoCap);
    drain(2000);
    repeat (20) @(posedge aclk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rx_frame_dma_feeder.md
# rx_frame_dma_feeder

Store-and-forward stage between the receive MAC stream and the AXI write DMA engine. It buffers whole frames, pairs each completed frame with a host buffer address, issues one write command (address, byte count) to the DMA, streams the frame words into the DMA data input, then reports a completion status for descriptor writeback.

## Interface
Parameters:
- DATA_AW, 10: data FIFO address bits; depth 2**DATA_AW 32-bit words.
- INFO_AW, 4: frame-info FIFO address bits; depth 2**INFO_AW frames.
- ADDRESS_BITS, 32: buffer address width.
- LENGTH_BITS, 16: byte-count width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- s_tdata  in  32  received frame data, packed.
- s_tkeep  in  4  byte enables; all ones except on the last beat, where they are contiguous from byte 0.
- s_tuser  in  1  frame error flag, sampled on the last beat.
- s_tlast, s_tvalid  in  1  stream control.
- s_tready  out  1  input accept.
- buf_addr  in  ADDRESS_BITS  free host buffer address, any byte alignment.
- buf_valid  in  1  buf_addr valid.
- buf_ready  out  1  buffer consumed.
- cmd_address  out  ADDRESS_BITS  DMA destination address.
- cmd_bytes  out  LENGTH_BITS  DMA byte count.
- cmd_valid  out  1  command valid.
- cmd_ready  in  1  DMA accepts the command.
- m_tdata, m_tkeep  out  32, 4  frame data to DMA.
- m_tlast, m_tvalid  out  1  stream control.
- m_tready  in  1  DMA data accept.
- stat_address  out  ADDRESS_BITS  buffer written.
- stat_bytes  out  LENGTH_BITS  frame length.
- stat_err  out  1  frame error or truncation.
- stat_valid  out  1  status valid.
- stat_ready  in  1  status accept.

## Operation
- Write side: a beat is accepted when s_tvalid is high and s_tready is high. The word is stored at wr_ptr, the byte counter adds popcount(s_tkeep), and wr_ptr increments.
- s_tready = !info_full. It stays high while the data FIFO is full, so there is no deadlock on oversize frames.
- Data FIFO full mid-frame: further beats are discarded up to and including tlast, and the frame is marked truncated (err=1). Stored bytes count only the accepted beats.
- On the tlast accept (or the end of a truncated frame):
  - The frame is committed: commit_ptr <= wr_ptr, and {bytes, err} are pushed to the info FIFO.
  - err = s_tuser | truncated.
  - A zero-byte frame (tlast with tkeep=0 and no prior beats) is discarded.
- The read side sees only committed words, so the occupancy check uses commit_ptr.
- Read FSM:
  - S_IDLE: go to S_CMD when the info FIFO is non-empty and buf_valid is high.
  - S_CMD: cmd_valid=1, cmd_address=buf_addr, cmd_bytes=info.bytes. When cmd_ready is high, buf_ready pulses for one cycle, the address is latched, words = ceil(bytes/4), and the FSM goes to S_DATA.
  - S_DATA: m_tvalid=1 while words remain. m_tkeep is 4'hF except on the last word, which uses the tail keep derived from bytes[1:0]. m_tlast is asserted on the last word. After the last handshake, the info FIFO pops and the FSM goes to S_STAT.
  - S_STAT: stat_valid=1 until stat_ready is high, then the FSM returns to S_IDLE.
- Widths: the byte counter is LENGTH_BITS and saturates at all-ones. Pointers are DATA_AW+1 bits with a wrap bit. The full/empty test compares the MSB and the remaining bits.

## Timing
- Reset values: s_tready=0 during reset and 1 the first cycle after; buf_ready=0, cmd_valid=0, m_tvalid=0, m_tlast=0, stat_valid=0. All pointers are 0 and the FSM is in S_IDLE. Data outputs are don't-care.
- Command latency: cmd_valid rises 2 cycles after the tlast accept, provided buf_valid is already high.
- m_tdata is registered from FIFO RAM with a one-word prefetch. Sustained throughput is 1 word/cycle under a continuous m_tready.
- cmd_valid, m_tvalid and stat_valid, once raised, hold with stable data until their handshake.
- The write side and read side operate concurrently. A commit and a pop in the same cycle update the info FIFO count correctly (count unchanged).
- Reset mid-operation aborts everything. Partial frames are lost, and no status is emitted.

## Configuration
- RX_ERR_DROP_EN defined: at commit, a frame with err=1 is discarded.
  - wr_ptr rewinds to commit_ptr, and no info entry is pushed.
  - No buffer is consumed, and no command or status is issued.
- RX_ERR_DROP_EN undefined: errored frames are DMA'd normally, and stat_err=1 is reported.

## Structure
- Shared package: FSM state enum (S_IDLE, S_CMD, S_DATA, S_STAT), the info-entry struct {bytes, err}, and the tail-keep function (bytes[1:0] to keep).
- One sub-module, rx_sdp_ram: a simple dual-port 32-bit RAM with registered read, used for the data FIFO. The info FIFO stays as inline registers.

## Test plan
- 64-byte good frame (16 beats), buf_addr=0x1000_0002, cmd_ready tied high -> one cmd (0x1000_0002, 64), 16 m beats with tlast on beat 16 and keep F, status (0x1000_0002, 64, err=0).
- 61-byte frame (last tkeep=4'h1) -> cmd_bytes=61, 16 words, last m_tkeep=4'h1.
- Errored frame (tuser=1 on tlast) followed by a good frame:
  - With RX_ERR_DROP_EN: only the good frame is DMA'd, and one buf_ready is consumed.
  - Without RX_ERR_DROP_EN: two commands are issued, and the first status has err=1.
- DATA_AW=4 with a 100-byte frame -> truncated to 64 bytes, err=1, and the next frame is unaffected.
- 16 back-to-back 60-byte frames, buf_valid low until all are input -> s_tready falls when the info FIFO is full, then all frames drain in order with correct lengths.
- Random m_tready/stat_ready backpressure plus a mid-frame reset -> outputs return to their reset values, and a frame sent after reset is transferred correctly.
